// File: rtl/bus_ram_responder.sv
// Word-addressed RAM behind a simple rd/wr/ready bus with a programmable access latency.
// Optional sequential-read fast path enabled by defining BUS_RAM_BURST_EN.
module bus_ram_responder #(
  parameter int LATENCY    = 2,
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready
);

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam bit         DIRECT = (LATENCY == 1);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic                  r_wr;
  logic                  r_ready;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [0:DEPTH-1];

  logic                  w_req;
  logic                  w_abort;
  logic                  w_burst_hit;
  logic [ADDR_WIDTH-1:0] w_idx_now;
  logic [ADDR_WIDTH-1:0] w_idx_lat;

  assign w_req     = bus_rd | bus_wr;
  assign w_abort   = !w_req || (bus_addr != r_addr);
  assign w_idx_now = bus_addr[ADDR_WIDTH+1:2];
  assign w_idx_lat = r_addr[ADDR_WIDTH+1:2];

`ifdef BUS_RAM_BURST_EN
  logic [29:0] r_last_word;
  logic        r_last_vld;

  // Next word in the same 64-byte line as the last completed read.
  assign w_burst_hit = r_last_vld && bus_rd && !bus_wr &&
                       (bus_addr[31:6] == r_last_word[29:4]) &&
                       (r_last_word[3:0] != 4'hF) &&
                       (bus_addr[5:2] == r_last_word[3:0] + 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_vld  <= 1'b0;
      r_last_word <= '0;
    end else if (r_state == IDLE && w_req) begin
      if (!w_burst_hit) r_last_vld <= 1'b0;
    end else if (r_state == READY && !r_wr) begin
      r_last_vld  <= 1'b1;
      r_last_word <= r_addr[31:2];
    end
  end
`else
  assign w_burst_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= bus_addr;
            r_wr    <= bus_wr;
            r_wdata <= bus_wdata;
            if (DIRECT || w_burst_hit) begin
              r_state <= READY;
              r_ready <= 1'b1;
              r_cnt   <= '0;
              if (!bus_wr) r_rdata <= r_mem[w_idx_now];
            end else begin
              r_state <= WAIT;
              r_cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (w_abort) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == 4'd1) begin
            r_state <= READY;
            r_ready <= 1'b1;
            r_cnt   <= '0;
            if (!r_wr) r_rdata <= r_mem[w_idx_lat];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        READY:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write commits on the edge leaving READY; a reset during READY leaves memory untouched.
  always_ff @(posedge clk) begin
    if (r_state == READY && r_wr) r_mem[w_idx_lat] <= r_wdata;
  end

  assign bus_rdata = r_rdata;
  assign bus_ready = r_ready;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed plus randomized check of bus_ram_responder against a word-array reference model.
module tb_bus_ram_responder;

  localparam int LATENCY = 2;
`ifdef BUS_RAM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bus_addr = '0;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  bus_ram_responder #(.LATENCY(LATENCY), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_model [int];
  logic [31:0] exp_rdata = '0;
  bit          exp_known = 1'b1;
  bit          rec_valid = 1'b0;
  logic [31:0] rec_addr = '0;
  logic [31:0] last_addr = '0;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFFF);
  endfunction

  function automatic int model_lat(input logic rd, input logic wr, input logic [31:0] a);
    bit seq;
    seq = rd && !wr && rec_valid && ((a >> 6) == (rec_addr >> 6)) && ((a >> 2) == (rec_addr >> 2) + 1);
    return (BURST && seq) ? 1 : LATENCY;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd);
    int exp_lat;
    int lat;
    exp_lat = model_lat(rd, wr, a);
    @(negedge clk);
    bus_rd = rd; bus_wr = wr; bus_addr = a; bus_wdata = wd;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (bus_ready === 1'b1) lat = i;
    end
    check32({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (wr) begin
      if (exp_known) check32({tag, "_rdata_hold"}, bus_rdata, exp_rdata);
      mem_model[widx(a)] = wd;
      rec_valid = 1'b0;
    end else begin
      if (mem_model.exists(widx(a))) begin
        exp_rdata = mem_model[widx(a)];
        exp_known = 1'b1;
        check32({tag, "_rdata"}, bus_rdata, exp_rdata);
      end else begin
        exp_known = 1'b0;
      end
      rec_valid = 1'b1;
      rec_addr  = a;
    end
    $display("%s: rd=%0b wr=%0b addr=%h wdata=%h latency=%0d rdata=%h", tag, rd, wr, a, wd, lat, bus_rdata);
    bus_rd = 1'b0; bus_wr = 1'b0;
    @(negedge clk);
    check32({tag, "_pulse_end"}, 32'(bus_ready), 32'd0);
  endtask

  initial begin
    int          seen;
    int          cyc;
    int          last_cyc;
    int          w;
    int          exp_sp;
    int          lat;
    logic [31:0] tmp;
    logic [31:0] a;
    int          op;

    // Reset state
    repeat (3) @(negedge clk);
    check32("reset_ready", 32'(bus_ready), 32'd0);
    check32("reset_rdata", bus_rdata, 32'd0);
    rst_n = 1'b1;

    // Write then read back
    do_access("wr40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    do_access("rd40", 1'b1, 1'b0, 32'h40, 32'h0);

    // Aborts
    do_access("wr100", 1'b0, 1'b1, 32'h100, 32'h01000100);
    do_access("wr104", 1'b0, 1'b1, 32'h104, 32'h01040104);
    do_access("wr108", 1'b0, 1'b1, 32'h108, 32'h01080108);
    @(negedge clk); bus_rd = 1'b1; bus_addr = 32'h100;
    @(negedge clk); bus_rd = 1'b0;
    seen = 0;
    repeat (LATENCY + 3) begin @(negedge clk); if (bus_ready === 1'b1) seen = 1; end
    check32("abort_rd_no_ready", 32'(seen), 32'd0);
    $display("abort_rd: addr=00000100 ready_seen=%0d", seen);
    rec_valid = 1'b0;
    do_access("rd104", 1'b1, 1'b0, 32'h104, 32'h0);

    @(negedge clk); bus_wr = 1'b1; bus_addr = 32'h104; bus_wdata = 32'hBADBAD00;
    @(negedge clk); bus_wr = 1'b0;
    seen = 0;
    repeat (LATENCY + 3) begin @(negedge clk); if (bus_ready === 1'b1) seen = 1; end
    check32("abort_wr_no_ready", 32'(seen), 32'd0);
    $display("abort_wr: addr=00000104 ready_seen=%0d", seen);
    rec_valid = 1'b0;
    do_access("rd104_keep", 1'b1, 1'b0, 32'h104, 32'h0);

    // Address change during WAIT restarts the access at the new address
    @(negedge clk); bus_rd = 1'b1; bus_addr = 32'h100;
    @(negedge clk); bus_addr = 32'h108;
    rec_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (bus_ready === 1'b1) lat = i;
    end
    check32("addr_change_lat", 32'(lat), 32'(LATENCY + 1));
    check32("addr_change_rdata", bus_rdata, 32'h01080108);
    $display("addr_change: addr=00000108 latency=%0d rdata=%h", lat, bus_rdata);
    exp_rdata = 32'h01080108; exp_known = 1'b1; rec_valid = 1'b1; rec_addr = 32'h108;
    bus_rd = 1'b0;
    @(negedge clk);

    // Cache-line fill with the request held across completions
    for (int i = 0; i < 16; i++) do_access("fillwr", 1'b0, 1'b1, 32'h1C0 + 32'(i * 4), 32'hC0DE0000 + 32'(i));
    @(negedge clk); bus_rd = 1'b1; bus_wr = 1'b0; bus_addr = 32'h1C0;
    exp_sp = model_lat(1'b1, 1'b0, bus_addr);
    cyc = 0; last_cyc = 0; w = 0;
    while (w < 16 && cyc < 300) begin
      @(negedge clk); cyc++;
      if (bus_ready === 1'b1) begin
        check32("fill_spacing", 32'(cyc - last_cyc), 32'(exp_sp));
        check32("fill_data", bus_rdata, mem_model[widx(bus_addr)]);
        $display("fill: word=%0d addr=%h spacing=%0d rdata=%h", w, bus_addr, cyc - last_cyc, bus_rdata);
        exp_rdata = mem_model[widx(bus_addr)]; exp_known = 1'b1;
        rec_valid = 1'b1; rec_addr = bus_addr;
        last_cyc = cyc; w++;
        bus_addr = bus_addr + 32'd4;
        exp_sp = model_lat(1'b1, 1'b0, bus_addr) + 1;
      end
    end
    bus_rd = 1'b0;
    check32("fill_count", 32'(w), 32'd16);
    @(negedge clk);

    // Line boundary
    do_access("wr38", 1'b0, 1'b1, 32'h38, 32'h00380038);
    do_access("wr3c", 1'b0, 1'b1, 32'h3C, 32'h003C003C);
    do_access("rd38", 1'b1, 1'b0, 32'h38, 32'h0);
    do_access("rd3c", 1'b1, 1'b0, 32'h3C, 32'h0);
    do_access("rd40_line", 1'b1, 1'b0, 32'h40, 32'h0);

    // Reset during WAIT of a write
    do_access("wr80", 1'b0, 1'b1, 32'h80, 32'h11111111);
    @(negedge clk); bus_wr = 1'b1; bus_addr = 32'h80; bus_wdata = 32'h22222222;
    @(negedge clk);
    rst_n = 1'b0; #1;
    check32("rst_wait_ready", 32'(bus_ready), 32'd0);
    check32("rst_wait_rdata", bus_rdata, 32'd0);
    $display("reset_in_wait: ready=%0b rdata=%h", bus_ready, bus_rdata);
    bus_wr = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_rdata = '0; exp_known = 1'b1; rec_valid = 1'b0;

    // Reset during READY of a write
    @(negedge clk); bus_wr = 1'b1; bus_addr = 32'h80; bus_wdata = 32'h33333333;
    repeat (LATENCY) @(negedge clk);
    check32("pre_rst_ready", 32'(bus_ready), 32'd1);
    rst_n = 1'b0; #1;
    check32("rst_ready_ready", 32'(bus_ready), 32'd0);
    $display("reset_in_ready: ready=%0b rdata=%h", bus_ready, bus_rdata);
    bus_wr = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_rdata = '0; exp_known = 1'b1; rec_valid = 1'b0;
    do_access("rd80", 1'b1, 1'b0, 32'h80, 32'h0);

    // Read and write together act as a write
    do_access("both20", 1'b1, 1'b1, 32'h20, 32'h5A5A5A5A);
    do_access("rd20", 1'b1, 1'b0, 32'h20, 32'h0);

    // Randomized traffic with address aliasing and sequential runs
    last_addr = 32'h20;
    for (int n = 0; n < 80; n++) begin
      op  = int'($urandom_range(0, 3));
      tmp = $urandom;
      if (op >= 2 && $urandom_range(0, 1) == 1) a = last_addr + 32'd4;
      else a = (tmp & 32'hFFFFC000) | (32'($urandom_range(0, 63)) << 2) | (tmp & 32'h3);
      case (op)
        0:       do_access("rnd_wr", 1'b0, 1'b1, a, $urandom);
        1:       do_access("rnd_both", 1'b1, 1'b1, a, $urandom);
        default: do_access("rnd_rd", 1'b1, 1'b0, a, 32'h0);
      endcase
      last_addr = a;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
